// File: rtl/calc_pkg.sv
// Shared types and sizes for the keypad calculator datapath.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int CALC_W = 8;
  localparam int PROD_W = 2 * CALC_W;

endpackage

// File: rtl/module_mult_dp.sv
// Shift-and-add datapath: holds the working register P and the captured multiplicand.
module module_mult_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ld,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod_next
);

  logic [2*WIDTH:0] r_p;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   w_upper;

  // Upper half is WIDTH+1 bits so the carry out of the add survives the shift.
  always_comb begin
    w_upper = r_p[2*WIDTH:WIDTH];
    if (r_p[0]) begin
      w_upper = r_p[2*WIDTH:WIDTH] + {1'b0, r_mcand};
    end
  end

  assign o_prod_next = {w_upper, r_p[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p     <= '0;
      r_mcand <= '0;
    end else if (i_ld) begin
      r_mcand <= i_a;
      r_p     <= {{(WIDTH+1){1'b0}}, i_b};
    end else if (i_step) begin
      r_p     <= {1'b0, o_prod_next};
    end
  end

endmodule

// File: rtl/module_mult_seq.sv
// Sequential unsigned multiplier: fixed WIDTH-cycle run, held product, one-cycle done pulse.
module module_mult_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output mult_state_t        state_dbg
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;
  logic               w_ld;
  logic               w_step;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_ld   = (r_state == IDLE) && start;
  assign w_step = (r_state == RUN) && !abort;

  module_mult_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .i_ld       (w_ld),
    .i_step     (w_step),
    .i_a        (a),
    .i_b        (b),
    .o_prod_next(w_prod_next)
  );

  // start is only looked at in IDLE, so it cannot be queued during RUN/DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_product <= w_prod_next;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign product   = r_product;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_module_mult_seq.sv
// Randomized self-checking bench for module_mult_seq against an arithmetic reference.
module tb_module_mult_seq;
  import calc_pkg::*;

  localparam int W = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic            abort;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;
  mult_state_t     state_dbg;

  int              n_checks;
  int              n_fail;
  logic [2*W-1:0]  last_prod;
  logic [2*W-1:0]  exp_q[$];

  module_mult_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every done must retire exactly one expected product
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        chk("sb_product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  // One operation. abort_at / ign_at: offset i (1..) of the edge k+i at which
  // abort / an extra start is sampled; 0 disables. abort_with_start raises abort
  // together with start in IDLE.
  task automatic mult_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input int abort_at, input int ign_at, input bit abort_with_start);
    logic [2*W-1:0] want;
    want = (2*W)'(op_a) * (2*W)'(op_b);
    @(negedge clk);
    start = 1'b1;
    abort = abort_with_start;
    a     = op_a;
    b     = op_b;
    if (abort_at == 0) exp_q.push_back(want);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("done_early", 32'(done), 32'd0);
    for (int i = 1; i <= W + 1; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i == abort_at) abort = 1'b1;
      if (i == ign_at) start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      if (abort_at != 0 && i >= abort_at) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_prod", 32'(product), 32'(last_prod));
        break;
      end else if (i < W) begin
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
        chk("run_prod_held", 32'(product), 32'(last_prod));
      end else if (i == W) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("product", 32'(product), 32'(want));
        last_prod = want;
      end else begin
        chk("done_fall", 32'(done), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("prod_hold", 32'(product), 32'(last_prod));
      end
    end
    @(negedge clk);
    chk("idle_after", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_prod = '0;
    rst   = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    a     = 8'h5A;
    b     = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    mult_op(8'h0C, 8'h0B, 0, 0, 1'b0);
    mult_op(8'hFF, 8'hFF, 0, 0, 1'b0);
    mult_op(8'h00, 8'hA5, 0, 0, 1'b0);
    mult_op(8'h01, 8'h80, 0, 0, 1'b0);
    mult_op(8'h05, 8'h07, 0, 3, 1'b0);
    mult_op(8'h10, 8'h10, 4, 0, 1'b0);
    mult_op(8'h10, 8'h10, 0, 0, 1'b0);
    mult_op(8'h21, 8'h13, 0, W + 1, 1'b0);
    mult_op(8'h7E, 8'h03, 0, 0, 1'b1);

    // abort while idle must not disturb anything
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_prod", 32'(product), 32'(last_prod));
    chk("idle_abort_busy", 32'(busy), 32'd0);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    a     = 8'h99;
    b     = 8'h77;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_prod", 32'(product), 32'd0);
    last_prod = '0;
    @(negedge clk);
    rst = 1'b1;
    mult_op(8'h03, 8'h04, 0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int ab;
      int ig;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : 0;
      ig = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W + 1) : 0;
      mult_op(W'($urandom), W'($urandom), ab, ig, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_mult_seq.md
# module_mult_seq

Sequential shift-and-add multiplier with its own control FSM. It replaces the combinational adder stage of the keypad calculator. It is started by the operand FSM once both operands `a` and `b` are loaded, computes `a*b` in a fixed number of cycles, and presents a held 16-bit product to the display path with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 8: operand width; the product is 2*WIDTH bits.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request pulse from the operand FSM (`load_m`). Sampled only in IDLE.
- `abort`  in  1: synchronous cancel of a running operation.
- `a`  in  WIDTH: multiplicand, unsigned.
- `b`  in  WIDTH: multiplier, unsigned.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse when `product` has just been updated.
- `product`  out  2*WIDTH: last completed result, held between operations.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 at an edge: capture `mcand`=a.
  - Load the working register P[2*WIDTH:0] = {0, b} (WIDTH+1 zero bits above b).
  - Clear the iteration counter `cnt`=0 and go to RUN.
- **RUN**, each edge:
  - If P[0]=1: P[2*WIDTH:WIDTH] += {0, mcand}. The add is WIDTH+1 bits wide, so no carry is lost.
  - Then P is shifted right by 1, and `cnt` += 1.
  - When the edge performing iteration `cnt`=WIDTH-1 occurs: `product` <= P[2*WIDTH-1:0] after the shift, and the state goes to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE on the next edge.
- Arithmetic is unsigned. The result is exact for all inputs and has no overflow: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Boundary conditions:
  - `start` in RUN or DONE is ignored, not queued. `a` and `b` may change freely after capture.
  - `abort`=1 in RUN returns to IDLE at that edge; `product` is unchanged and no `done` pulse occurs.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `start` together in IDLE: `start` wins.
  - `start` in the cycle DONE→IDLE is ignored, because `start` is only sampled in IDLE. Back-to-back operations need a 1-cycle gap.
  - Reset mid-operation: the FSM goes to IDLE and all registers clear immediately (asynchronous).
  - Zero operands take the same fixed latency; there is no early exit.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `product`=0, P=0, `mcand`=0, `cnt`=0.
- `start` accepted at edge k:
  - `busy` rises after edge k.
  - `product` is valid after edge k+WIDTH.
  - `done` is high in the cycle between edges k+WIDTH and k+WIDTH+1.
  - `busy` falls after edge k+WIDTH+1.
- With WIDTH=8: result after 8 edges past the start edge; a new `start` is accepted at edge k+10 at the earliest.
- `done` and `busy` are decoded from registered state only, with no combinational path from inputs. `product` is a register output.

## Structure
- Shared package `calc_pkg`:
  - state typedef `mult_state_t` {IDLE, RUN, DONE}
  - constant `CALC_W`=8, used as the default `WIDTH` at the top level
  - `PROD_W`=2*CALC_W
- Optional sub-module `module_mult_dp`: holds P, `mcand` and the add/shift step, controlled by `ld` and `step` from the FSM. It may stay inline; one file is acceptable.
- Top-level integration:
  - `module_suma` is replaced by this block.
  - `start` is driven by `load_m`.
  - `product` feeds the display path.

## Test plan
- Reset: hold `rst`=0 with `start`=1 → `busy`=0, `done`=0, `product`=0x0000. After release, no operation starts until a `start` is sampled.
- Basic: a=0x0C, b=0x0B, start at edge k → `product`=0x0084 after edge k+8; `done` high only in the next cycle; `busy` high for 9 cycles.
- Extremes: 0xFF×0xFF → 0xFE01. Then 0x00×0xA5 → 0x0000 with the same latency. Then 0x01×0x80 → 0x0080.
- Ignored start: pulse `start` with a=0x02,b=0x03 at k+3 during a 0x05×0x07 run → product 0x0023, a single `done`, and no second operation.
- Abort: start 0x10×0x10, assert `abort` at edge k+4 → IDLE after edge k+4, `product` keeps its previous value, no `done`. A subsequent start completes correctly (0x0100).
- Reset mid-run: drop `rst` at k+5 → `busy`=0 and `product`=0 immediately (asynchronous). After release, a new 0x03×0x04 yields 0x000C.
